pattern_count_ctrl: RTL and testbench

PATTERN_COUNT_CTRL -- requirements
Module: pattern_count_ctrl

---
 rtl/pattern_count_ctrl.sv | 147 ++++++++++++++
 tb/tb_pattern_count_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pattern_count_ctrl
// Summary  : Fetches an 8-byte string from data memory and counts 4-bit
//            pattern matches, both within single bytes and across the string.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_count_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] pat,
  input  logic [7:0] base_addr,
  output logic       mem_rd,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] ctb,
  output logic [7:0] cts
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] c_FETCH_LAST = 6'd8;
  localparam logic [5:0] c_SCAN_LAST  = 6'd60;
  localparam logic [5:0] c_CTS_LAST   = 6'd58;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [3:0]  r_pat;
  logic [7:0]  r_base;
  logic [63:0] r_str;
  logic [7:0]  r_acc_b;
  logic [7:0]  r_acc_s;
  logic        r_mem_rd;
  logic [7:0]  r_mem_addr;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_ctb;
  logic [7:0]  r_cts;

  logic [3:0]  w_win;
  logic        w_hit;
  logic        w_inc_b;
  logic        w_inc_s;
  logic [7:0]  w_next_addr;

  assign w_win       = r_str[r_cnt +: 4];
  assign w_hit       = (w_win == r_pat);
  assign w_inc_b     = w_hit && (r_cnt[2:0] <= 3'd4);
  assign w_inc_s     = w_hit && (r_cnt <= c_CTS_LAST);
  assign w_next_addr = r_base + {2'b00, r_cnt} + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pat      <= '0;
      r_base     <= '0;
      r_str      <= '0;
      r_acc_b    <= '0;
      r_acc_s    <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ctb      <= '0;
      r_cts      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_cnt      <= '0;
            r_pat      <= pat;
            r_base     <= base_addr;
            r_str      <= '0;
            r_acc_b    <= '0;
            r_acc_s    <= '0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= base_addr;
            r_busy     <= 1'b1;
          end
        end

        S_FETCH: begin
          // Read data trails the strobe by one cycle, so bytes land in cycles 1..8.
          if (r_cnt != 6'd0) begin
            r_str <= {r_str[55:0], mem_rdata};
          end
          if (r_cnt < 6'd7) begin
            r_mem_addr <= w_next_addr;
          end else begin
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
          end
          if (r_cnt == c_FETCH_LAST) begin
            r_state <= S_SCAN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end

        S_SCAN: begin
          r_acc_b <= r_acc_b + {7'd0, w_inc_b};
          r_acc_s <= r_acc_s + {7'd0, w_inc_s};
          if (r_cnt == c_SCAN_LAST) begin
            // Fold in the final window's contribution on the way out.
            r_ctb   <= r_acc_b + {7'd0, w_inc_b};
            r_cts   <= r_acc_s + {7'd0, w_inc_s};
            r_done  <= 1'b1;
            r_state <= S_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ctb      = r_ctb;
  assign cts      = r_cts;

endmodule
`default_nettype wire

// File: tb/tb_pattern_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_count_ctrl
// Summary  : Randomized and directed self-checking bench for pattern_count_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_count_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] pat;
  logic [7:0] base_addr;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic [7:0] ctb;
  logic [7:0] cts;

  logic [7:0] mem [256];
  int n_tests;
  int n_fail;

  pattern_count_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pat       (pat),
    .base_addr (base_addr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .ctb       (ctb),
    .cts       (cts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: concatenate bytes (first byte most significant) and slide a nibble window.
  task automatic ref_counts(input logic [7:0] b [8], input logic [3:0] p,
                            output int eb, output int es);
    logic [63:0] s;
    logic [3:0]  w;
    for (int n = 0; n < 8; n++) s[63-8*n -: 8] = b[n];
    eb = 0;
    es = 0;
    for (int j = 0; j <= 60; j++) begin
      w = s[j +: 4];
      if (w == p) begin
        if (j <= 58) es++;
        if ((j % 8) <= 4) eb++;
      end
    end
  endtask

  task automatic load_bytes(input logic [7:0] b [8], input logic [7:0] base);
    for (int n = 0; n < 8; n++) mem[8'(base + 8'(n))] = b[n];
  endtask

  // Runs one job; returns at #1 after the edge following DONE (IDLE cycle).
  task automatic run_job(input string tag, input logic [7:0] b [8], input logic [3:0] p,
                         input logic [7:0] base, input bit b2b, input bit disturb);
    int eb, es, done_k, done_cnt, nrd;
    bit addr_ok;
    load_bytes(b, base);
    ref_counts(b, p, eb, es);
    if (!b2b) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    pat = p;
    base_addr = base;
    @(posedge clk);
    #1;
    start = 1'b0;
    pat = ~p;
    base_addr = base + 8'd37;
    done_k = -1;
    done_cnt = 0;
    nrd = 0;
    addr_ok = 1'b1;
    chk({tag, " busy_start"}, 32'(busy), 32'd1);
    for (int k = 0; k <= 71; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (mem_rd) begin
        if (mem_addr !== 8'(base + 8'(nrd))) addr_ok = 1'b0;
        nrd++;
      end
      if (k == 8) chk({tag, " drain_rd"}, 32'(mem_rd), 32'd0);
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k == 70) chk({tag, " busy_done"}, 32'(busy), 32'd1);
      if (disturb && k == 40) begin
        start = 1'b1;
        pat = p + 4'd1;
      end
      if (disturb && k == 41) start = 1'b0;
    end
    chk({tag, " rd_count"}, 32'(nrd), 32'd8);
    chk({tag, " addr_seq"}, 32'(addr_ok), 32'd1);
    chk({tag, " done_lat"}, 32'(done_k), 32'd70);
    chk({tag, " done_w"}, 32'(done_cnt), 32'd1);
    chk({tag, " busy_idle"}, 32'(busy), 32'd0);
    chk({tag, " ctb"}, 32'(ctb), 32'(eb));
    chk({tag, " cts"}, 32'(cts), 32'(es));
  endtask

  initial begin
    logic [7:0] b [8];
    int eb, es;
    bit saw_done;
    n_tests = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    start = 1'b0;
    pat = 4'h0;
    base_addr = 8'h00;
    rst_n = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst rd", 32'(mem_rd), 32'd0);
    chk("rst addr", 32'(mem_addr), 32'd0);
    chk("rst ctb", 32'(ctb), 32'd0);
    chk("rst cts", 32'(cts), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors with hand-derived results
    for (int n = 0; n < 8; n++) b[n] = 8'h00;
    run_job("zero_p0", b, 4'h0, 8'h10, 1'b0, 1'b0);
    chk("zero_p0 ctb40", 32'(ctb), 32'd40);
    chk("zero_p0 cts59", 32'(cts), 32'd59);
    run_job("zero_p1", b, 4'h1, 8'h10, 1'b1, 1'b0);
    chk("zero_p1 ctb0", 32'(ctb), 32'd0);
    chk("zero_p1 cts0", 32'(cts), 32'd0);
    for (int n = 0; n < 8; n++) b[n] = 8'hAA;
    run_job("aa", b, 4'hA, 8'h20, 1'b0, 1'b0);
    chk("aa ctb24", 32'(ctb), 32'd24);
    chk("aa cts30", 32'(cts), 32'd30);
    for (int n = 0; n < 8; n++) b[n] = 8'h00;
    b[6] = 8'h01;
    b[7] = 8'h80;
    run_job("cross", b, 4'h3, 8'h30, 1'b0, 1'b0);
    chk("cross ctb0", 32'(ctb), 32'd0);
    chk("cross cts1", 32'(cts), 32'd1);
    for (int n = 0; n < 8; n++) b[n] = 8'(8'h5C + 8'(n * 17));
    run_job("wrap", b, 4'h7, 8'hFC, 1'b0, 1'b0);
    run_job("disturb", b, 4'hC, 8'h40, 1'b0, 1'b1);

    // Reset in SCAN cycle 30 aborts the job
    for (int n = 0; n < 8; n++) b[n] = 8'hFF;
    load_bytes(b, 8'h50);
    @(posedge clk);
    #1;
    start = 1'b1;
    pat = 4'hF;
    base_addr = 8'h50;
    @(posedge clk);
    #1;
    start = 1'b0;
    saw_done = 1'b0;
    for (int k = 1; k <= 39; k++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort ctb", 32'(ctb), 32'd0);
    chk("abort cts", 32'(cts), 32'd0);
    chk("abort rd", 32'(mem_rd), 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
      if (k == 2) rst_n = 1'b1;
    end
    chk("abort no_done", 32'(saw_done), 32'd0);
    for (int n = 0; n < 8; n++) b[n] = 8'hAA;
    run_job("post_rst", b, 4'hA, 8'h60, 1'b0, 1'b0);
    chk("post_rst ctb24", 32'(ctb), 32'd24);
    chk("post_rst cts30", 32'(cts), 32'd30);

    // Randomized jobs against the reference
    for (int t = 0; t < 12; t++) begin
      for (int n = 0; n < 8; n++) begin
        b[n] = 8'($urandom);
        if ($urandom_range(0, 3) == 0) b[n] = {2{4'($urandom_range(0, 15))}};
      end
      run_job("rand", b, 4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
